// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared opcode, ALU_op, mux encodings, FSM state type and the
//            control word produced by the multi-cycle main control unit.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [1:0] ALUOP_ADD  = 2'b00;
   localparam logic [1:0] ALUOP_SUB  = 2'b01;
   localparam logic [1:0] ALUOP_FUNC = 2'b10;

   localparam logic [1:0] ASB_RT      = 2'b00;
   localparam logic [1:0] ASB_FOUR    = 2'b01;
   localparam logic [1:0] ASB_IMM     = 2'b10;
   localparam logic [1:0] ASB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCS_ALU    = 2'b00;
   localparam logic [1:0] PCS_ALUOUT = 2'b01;
   localparam logic [1:0] PCS_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_FETCH     = 4'd1,
      S_DECODE    = 4'd2,
      S_MEM_ADDR  = 4'd3,
      S_MEM_READ  = 4'd4,
      S_MEM_WB    = 4'd5,
      S_MEM_WRITE = 4'd6,
      S_R_EXEC    = 4'd7,
      S_R_WB      = 4'd8,
      S_BRANCH    = 4'd9,
      S_JUMP      = 4'd10,
      S_ADDI_EXEC = 4'd11,
      S_ADDI_WB   = 4'd12
   } state_t;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       illegal_op;
   } ctrl_t;

   function automatic logic is_legal_op(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_LW)  || (op == OP_SW) ||
             (op == OP_BEQ)   || (op == OP_J)   || (op == OP_ADDI);
   endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/main_control_outputs.sv
`default_nettype none
// ============================================================================
// Module   : main_control_outputs
// Purpose  : Pure decode of FSM state (plus mem_ready in FETCH and opcode in
//            DECODE) into the datapath control word.
// Revision : 1.0 - initial release
// ============================================================================
module main_control_outputs
   import cpu_pkg::*;
(
   input  state_t     i_state,
   input  logic       i_mem_ready,
   input  logic [5:0] i_opcode,
   output ctrl_t      o_ctrl
);

   always_comb begin
      o_ctrl = '0;
      case (i_state)
         S_FETCH: begin
            o_ctrl.mem_read  = 1'b1;
            o_ctrl.alu_src_b = ASB_FOUR;
            o_ctrl.alu_op    = ALUOP_ADD;
            o_ctrl.pc_source = PCS_ALU;
            // IR and PC load only in the cycle the instruction word arrives
            o_ctrl.ir_write  = i_mem_ready;
            o_ctrl.pc_write  = i_mem_ready;
         end
         S_DECODE: begin
            o_ctrl.alu_src_b  = ASB_IMM_SH2;
            o_ctrl.alu_op     = ALUOP_ADD;
            o_ctrl.illegal_op = ~is_legal_op(i_opcode);
         end
         S_MEM_ADDR, S_ADDI_EXEC: begin
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_src_b = ASB_IMM;
            o_ctrl.alu_op    = ALUOP_ADD;
         end
         S_MEM_READ: begin
            o_ctrl.mem_read = 1'b1;
            o_ctrl.i_or_d   = 1'b1;
         end
         S_MEM_WB: begin
            o_ctrl.reg_write  = 1'b1;
            o_ctrl.mem_to_reg = 1'b1;
         end
         S_MEM_WRITE: begin
            o_ctrl.mem_write = 1'b1;
            o_ctrl.i_or_d    = 1'b1;
         end
         S_R_EXEC: begin
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_src_b = ASB_RT;
            o_ctrl.alu_op    = ALUOP_FUNC;
         end
         S_R_WB: begin
            o_ctrl.reg_write = 1'b1;
            o_ctrl.reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            o_ctrl.alu_src_a     = 1'b1;
            o_ctrl.alu_src_b     = ASB_RT;
            o_ctrl.alu_op        = ALUOP_SUB;
            o_ctrl.pc_write_cond = 1'b1;
            o_ctrl.pc_source     = PCS_ALUOUT;
         end
         S_JUMP: begin
            o_ctrl.pc_write  = 1'b1;
            o_ctrl.pc_source = PCS_JUMP;
         end
         S_ADDI_WB: begin
            o_ctrl.reg_write = 1'b1;
         end
         default: o_ctrl = '0;
      endcase
   end

endmodule : main_control_outputs
`default_nettype wire

// File: rtl/main_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : main_control_fsm
// Purpose  : Multi-cycle MIPS main control: state register, next-state logic
//            and reset gating of the decoded control word.
// Revision : 1.0 - initial release
// ============================================================================
module main_control_fsm
   import cpu_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] ALU_op,
   output logic [1:0] pc_source,
   output logic       illegal_op
);

   state_t r_state;
   state_t w_next_state;
   ctrl_t  w_ctrl_dec;
   ctrl_t  w_ctrl;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:      w_next_state = S_FETCH;
         S_FETCH:     w_next_state = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: w_next_state = S_MEM_ADDR;
               OP_RTYPE:     w_next_state = S_R_EXEC;
               OP_BEQ:       w_next_state = S_BRANCH;
               OP_J:         w_next_state = S_JUMP;
               OP_ADDI:      w_next_state = S_ADDI_EXEC;
               default:      w_next_state = S_FETCH;
            endcase
         end
         S_MEM_ADDR:  w_next_state = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
         S_MEM_READ:  w_next_state = mem_ready ? S_MEM_WB : S_MEM_READ;
         S_MEM_WB:    w_next_state = S_FETCH;
         S_MEM_WRITE: w_next_state = mem_ready ? S_FETCH : S_MEM_WRITE;
         S_R_EXEC:    w_next_state = S_R_WB;
         S_R_WB:      w_next_state = S_FETCH;
         S_BRANCH:    w_next_state = S_FETCH;
         S_JUMP:      w_next_state = S_FETCH;
         S_ADDI_EXEC: w_next_state = S_ADDI_WB;
         S_ADDI_WB:   w_next_state = S_FETCH;
         default:     w_next_state = S_IDLE;
      endcase
   end

   main_control_outputs u_outputs (
      .i_state     (r_state),
      .i_mem_ready (mem_ready),
      .i_opcode    (opcode),
      .o_ctrl      (w_ctrl_dec)
   );

   // Reset takes effect at the next edge; blank outputs in the reset cycle itself
   assign w_ctrl = rst ? '0 : w_ctrl_dec;

   assign pc_write      = w_ctrl.pc_write;
   assign pc_write_cond = w_ctrl.pc_write_cond;
   assign i_or_d        = w_ctrl.i_or_d;
   assign mem_read      = w_ctrl.mem_read;
   assign mem_write     = w_ctrl.mem_write;
   assign ir_write      = w_ctrl.ir_write;
   assign mem_to_reg    = w_ctrl.mem_to_reg;
   assign reg_dst       = w_ctrl.reg_dst;
   assign reg_write     = w_ctrl.reg_write;
   assign alu_src_a     = w_ctrl.alu_src_a;
   assign alu_src_b     = w_ctrl.alu_src_b;
   assign ALU_op        = w_ctrl.alu_op;
   assign pc_source     = w_ctrl.pc_source;
   assign illegal_op    = w_ctrl.illegal_op;

endmodule : main_control_fsm
`default_nettype wire

// File: tb/tb_main_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_main_control_fsm
// Purpose  : Directed, self-checking bench for main_control_fsm.
// Revision : 1.0 - initial release
// ============================================================================
module tb_main_control_fsm;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
   logic [1:0] alu_src_b, ALU_op, pc_source;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   main_control_fsm dut (
      .clk           (clk),
      .rst           (rst),
      .opcode        (opcode),
      .mem_ready     (mem_ready),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .i_or_d        (i_or_d),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .ir_write      (ir_write),
      .mem_to_reg    (mem_to_reg),
      .reg_dst       (reg_dst),
      .reg_write     (reg_write),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .ALU_op        (ALU_op),
      .pc_source     (pc_source),
      .illegal_op    (illegal_op)
   );

   // Observed word: {pcw,pcc,iod,mr,mw,irw,m2r,rd,rw,asa,asb[2],aop[2],pcs[2],ill}
   logic [16:0] w_obs;
   assign w_obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, ALU_op,
                   pc_source, illegal_op};

   // Expected control words, written out field by field from the state table
   localparam logic [16:0] E_ZERO    = {10'b0000000000, 2'b00, 2'b00, 2'b00, 1'b0};
   localparam logic [16:0] E_FETCH_W = {10'b0001000000, 2'b01, 2'b00, 2'b00, 1'b0};
   localparam logic [16:0] E_FETCH_R = {10'b1001010000, 2'b01, 2'b00, 2'b00, 1'b0};
   localparam logic [16:0] E_DECODE  = {10'b0000000000, 2'b11, 2'b00, 2'b00, 1'b0};
   localparam logic [16:0] E_DEC_ILL = {10'b0000000000, 2'b11, 2'b00, 2'b00, 1'b1};
   localparam logic [16:0] E_ADDR    = {10'b0000000001, 2'b10, 2'b00, 2'b00, 1'b0};
   localparam logic [16:0] E_MRD     = {10'b0011000000, 2'b00, 2'b00, 2'b00, 1'b0};
   localparam logic [16:0] E_MWB     = {10'b0000001010, 2'b00, 2'b00, 2'b00, 1'b0};
   localparam logic [16:0] E_MWR     = {10'b0010100000, 2'b00, 2'b00, 2'b00, 1'b0};
   localparam logic [16:0] E_REXEC   = {10'b0000000001, 2'b00, 2'b10, 2'b00, 1'b0};
   localparam logic [16:0] E_RWB     = {10'b0000000110, 2'b00, 2'b00, 2'b00, 1'b0};
   localparam logic [16:0] E_BRANCH  = {10'b0100000001, 2'b00, 2'b01, 2'b01, 1'b0};
   localparam logic [16:0] E_JUMP    = {10'b1000000000, 2'b00, 2'b00, 2'b10, 1'b0};
   localparam logic [16:0] E_AWB     = {10'b0000000010, 2'b00, 2'b00, 2'b00, 1'b0};

   localparam logic [5:0] OPC_R   = 6'b000000;
   localparam logic [5:0] OPC_LW  = 6'b100011;
   localparam logic [5:0] OPC_SW  = 6'b101011;
   localparam logic [5:0] OPC_BEQ = 6'b000100;
   localparam logic [5:0] OPC_J   = 6'b000010;
   localparam logic [5:0] OPC_ADD = 6'b001000;
   localparam logic [5:0] OPC_BAD = 6'b111111;

   // Drive inputs at the falling edge, check 1 ns later, advance one cycle
   task automatic cyc(input logic mr, input logic [5:0] op,
                      input logic [16:0] exp, input string tag);
      mem_ready = mr;
      opcode    = op;
      #1;
      n_vec++;
      assert (w_obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %05h expected %05h", tag, w_obs, exp);
      end
      @(negedge clk);
   endtask

   initial begin
      rst       = 1'b1;
      mem_ready = 1'b0;
      opcode    = OPC_R;
      @(negedge clk);
      cyc(1'b0, OPC_R, E_ZERO, "reset_out");
      rst = 1'b0;
      cyc(1'b0, OPC_R, E_ZERO,    "idle");

      // R-type, zero wait
      cyc(1'b1, OPC_R, E_FETCH_R, "r_fetch");
      cyc(1'b1, OPC_R, E_DECODE,  "r_decode");
      cyc(1'b1, OPC_R, E_REXEC,   "r_exec");
      cyc(1'b0, OPC_R, E_RWB,     "r_wb");

      // lw with two wait cycles in MEM_READ
      cyc(1'b1, OPC_LW, E_FETCH_R, "lw_fetch");
      cyc(1'b0, OPC_LW, E_DECODE,  "lw_decode");
      cyc(1'b0, OPC_LW, E_ADDR,    "lw_addr");
      cyc(1'b0, OPC_LW, E_MRD,     "lw_rd_wait1");
      cyc(1'b0, OPC_LW, E_MRD,     "lw_rd_wait2");
      cyc(1'b1, OPC_LW, E_MRD,     "lw_rd_done");
      cyc(1'b0, OPC_LW, E_MWB,     "lw_wb");

      // sw, one wait cycle
      cyc(1'b1, OPC_SW, E_FETCH_R, "sw_fetch");
      cyc(1'b0, OPC_SW, E_DECODE,  "sw_decode");
      cyc(1'b0, OPC_SW, E_ADDR,    "sw_addr");
      cyc(1'b0, OPC_SW, E_MWR,     "sw_wait");
      cyc(1'b1, OPC_SW, E_MWR,     "sw_done");

      // beq and j
      cyc(1'b1, OPC_BEQ, E_FETCH_R, "beq_fetch");
      cyc(1'b0, OPC_BEQ, E_DECODE,  "beq_decode");
      cyc(1'b1, OPC_BEQ, E_BRANCH,  "beq_branch");
      cyc(1'b1, OPC_J,   E_FETCH_R, "j_fetch");
      cyc(1'b0, OPC_J,   E_DECODE,  "j_decode");
      cyc(1'b0, OPC_J,   E_JUMP,    "j_jump");

      // addi
      cyc(1'b1, OPC_ADD, E_FETCH_R, "addi_fetch");
      cyc(1'b0, OPC_ADD, E_DECODE,  "addi_decode");
      cyc(1'b0, OPC_ADD, E_ADDR,    "addi_exec");
      cyc(1'b0, OPC_ADD, E_AWB,     "addi_wb");

      // Illegal opcode pulses once, then back to FETCH
      cyc(1'b1, OPC_BAD, E_FETCH_R, "ill_fetch");
      cyc(1'b1, OPC_BAD, E_DEC_ILL, "ill_decode");
      cyc(1'b0, OPC_BAD, E_FETCH_W, "ill_refetch");

      // FETCH stall: three more wait cycles (four total), then load
      cyc(1'b0, OPC_R, E_FETCH_W, "stall_2");
      cyc(1'b0, OPC_R, E_FETCH_W, "stall_3");
      cyc(1'b0, OPC_R, E_FETCH_W, "stall_4");
      cyc(1'b1, OPC_R, E_FETCH_R, "stall_load");
      cyc(1'b0, OPC_R, E_DECODE,  "stall_decode");
      cyc(1'b0, OPC_R, E_REXEC,   "stall_exec");
      cyc(1'b0, OPC_R, E_RWB,     "stall_wb");

      // Reset held for three cycles in the middle of a MEM_READ wait
      cyc(1'b1, OPC_LW, E_FETCH_R, "rst_fetch");
      cyc(1'b0, OPC_LW, E_DECODE,  "rst_decode");
      cyc(1'b0, OPC_LW, E_ADDR,    "rst_addr");
      cyc(1'b0, OPC_LW, E_MRD,     "rst_rd_wait");
      rst = 1'b1;
      cyc(1'b0, OPC_LW, E_ZERO, "rst_cyc1");
      cyc(1'b1, OPC_LW, E_ZERO, "rst_cyc2");
      cyc(1'b1, OPC_LW, E_ZERO, "rst_cyc3");
      rst = 1'b0;
      cyc(1'b0, OPC_LW, E_ZERO,    "rst_idle");
      cyc(1'b0, OPC_LW, E_FETCH_W, "rst_fetch_after");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_main_control_fsm
`default_nettype wire
